// File: rtl/pll_mode_ctrl.sv
// pll_mode_ctrl: retune sequencer for a dynamically configured PLL. It looks up divider codes per video mode,
// pulses the PLL reset, waits for lock with timeout/retry and requires a clean settle window.
module pll_mode_ctrl #(
    parameter int NUM_MODES     = 4,
    parameter int MODE_W        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
    parameter int DIV_W         = 6,
    parameter logic [NUM_MODES*DIV_W-1:0] FBDSEL_TABLE = '0,
    parameter logic [NUM_MODES*DIV_W-1:0] IDSEL_TABLE  = '0,
    parameter logic [NUM_MODES*DIV_W-1:0] ODSEL_TABLE  = '0,
    parameter int DEFAULT_MODE  = 0,
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [MODE_W-1:0] mode_req,
    input  logic              mode_req_valid,
    output logic              mode_req_ready,
    input  logic              pll_lock,
    output logic [DIV_W-1:0]  fbdsel,
    output logic [DIV_W-1:0]  idsel,
    output logic [DIV_W-1:0]  odsel,
    output logic              pll_reset,
    output logic              video_rst,
    output logic [MODE_W-1:0] mode_active,
    output logic              busy,
    output logic              error,
    output logic              lock_lost
);

    localparam int CNT_MAX_A = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RTY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [RTY_W-1:0]  RTY_MAX     = RTY_W'(MAX_RETRIES);
    localparam logic [RTY_W-1:0]  RTY_ONE     = RTY_W'(1);
    localparam logic [MODE_W-1:0] DEF_MODE    = MODE_W'(DEFAULT_MODE);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_APPLY     = 3'd1,
        ST_PLL_RST   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_FAIL      = 3'd5
    } state_t;

    function automatic logic [DIV_W-1:0] table_code(input logic [NUM_MODES*DIV_W-1:0] tbl,
                                                    input logic [MODE_W-1:0] idx);
        table_code = tbl[int'(idx) * DIV_W +: DIV_W];
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RTY_W-1:0]  rty_q, rty_d;
    logic [MODE_W-1:0] target_q, target_d;
    logic [MODE_W-1:0] active_q, active_d;
    logic [DIV_W-1:0]  fb_q, fb_d, id_q, id_d, od_q, od_d;
    logic              pll_rst_q, pll_rst_d;
    logic              vrst_q, vrst_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              lost_q, lost_d;
    logic              lock_s;
    logic              req_ok_s;
    logic              accept_s;

    assign lock_s   = sync_q[1];
    assign req_ok_s = ({{(32-MODE_W){1'b0}}, mode_req} < 32'(NUM_MODES));
    assign accept_s = ((state_q == ST_IDLE) || (state_q == ST_FAIL)) && mode_req_valid && req_ok_s;

    // Two-flop synchroniser for the asynchronous lock indicator.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    // Next-state and next-output logic; every output is registered from the next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rty_d    = rty_q;
        target_d = target_q;
        active_d = active_q;
        fb_d     = fb_q;
        id_d     = id_q;
        od_d     = od_q;
        err_d    = err_q;
        lost_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (mode_req_valid && !req_ok_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                // Selects load on the accept edge so they are already valid during APPLY.
                if (accept_s) begin
                    target_d = mode_req;
                    rty_d    = '0;
                    fb_d     = table_code(FBDSEL_TABLE, mode_req);
                    id_d     = table_code(IDSEL_TABLE, mode_req);
                    od_d     = table_code(ODSEL_TABLE, mode_req);
                    state_d  = ST_APPLY;
                end else if ((state_q == ST_IDLE) && !lock_s) begin
                    target_d = active_q;
                    rty_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_WAIT_LOCK;
                end else begin
                    state_d  = state_q;
                end
                lost_d = (state_q == ST_IDLE) && !lock_s;
            end
            ST_APPLY: begin
                cnt_d   = '0;
                state_d = ST_PLL_RST;
            end
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else if (cnt_q == LOCK_LAST) begin
                    cnt_d = '0;
                    if (rty_q < RTY_MAX) begin
                        rty_d   = rty_q + RTY_ONE;
                        state_d = ST_PLL_RST;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == SETTLE_LAST) begin
                    active_d = target_q;
                    err_d    = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_PLL_RST;
            end
        endcase
        pll_rst_d = (state_d == ST_PLL_RST);
        vrst_d    = (state_d != ST_IDLE);
        ready_d   = (state_d == ST_IDLE) || (state_d == ST_FAIL);
        busy_d    = !ready_d;
    end

    // State and output registers; reset restarts bring-up of the default mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_PLL_RST;
            cnt_q     <= '0;
            rty_q     <= '0;
            target_q  <= DEF_MODE;
            active_q  <= DEF_MODE;
            fb_q      <= table_code(FBDSEL_TABLE, DEF_MODE);
            id_q      <= table_code(IDSEL_TABLE, DEF_MODE);
            od_q      <= table_code(ODSEL_TABLE, DEF_MODE);
            pll_rst_q <= 1'b1;
            vrst_q    <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rty_q     <= rty_d;
            target_q  <= target_d;
            active_q  <= active_d;
            fb_q      <= fb_d;
            id_q      <= id_d;
            od_q      <= od_d;
            pll_rst_q <= pll_rst_d;
            vrst_q    <= vrst_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
        end
    end

    assign mode_req_ready = ready_q;
    assign fbdsel         = fb_q;
    assign idsel          = id_q;
    assign odsel          = od_q;
    assign pll_reset      = pll_rst_q;
    assign video_rst      = vrst_q;
    assign mode_active    = active_q;
    assign busy           = busy_q;
    assign error          = err_q;
    assign lock_lost      = lost_q;

endmodule

// File: tb/tb_pll_mode_ctrl.sv
`timescale 1ns/1ps
// Bench for pll_mode_ctrl: scenario tasks drive requests and the PLL lock line, and compare against
// expectations derived from the retune rules (2-cycle lock sync, reset pulse, timeout, settle window).
module tb_pll_mode_ctrl;

    localparam int NM = 4;
    localparam int MW = 3;
    localparam int DW = 6;
    localparam int RC = 4;
    localparam int LT = 100;
    localparam int SC = 8;
    localparam int MR = 2;
    // lock edge -> two sync flops -> WAIT_LOCK exit -> SC locked cycles in SETTLE
    localparam int LOCK_TO_RUN = 2 + 1 + SC;

    localparam logic [NM*DW-1:0] FB_T = {6'd43, 6'd32, 6'd21, 6'd10};
    localparam logic [NM*DW-1:0] ID_T = {6'd4, 6'd3, 6'd2, 6'd1};
    localparam logic [NM*DW-1:0] OD_T = {6'd56, 6'd48, 6'd40, 6'd33};

    int fb_tab[NM] = '{10, 21, 32, 43};
    int id_tab[NM] = '{1, 2, 3, 4};
    int od_tab[NM] = '{33, 40, 48, 56};

    logic          clk;
    logic          reset;
    logic [MW-1:0] mode_req;
    logic          mode_req_valid;
    logic          mode_req_ready;
    logic          pll_lock;
    logic [DW-1:0] fbdsel, idsel, odsel;
    logic          pll_reset, video_rst;
    logic [MW-1:0] mode_active;
    logic          busy, error, lock_lost;
    logic [4:0]    st;
    logic [17:0]   sel;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_active = 0;
    int exp_error = 0;

    assign st  = {busy, mode_req_ready, video_rst, error, lock_lost};
    assign sel = {fbdsel, idsel, odsel};

    pll_mode_ctrl #(
        .NUM_MODES(NM), .MODE_W(MW), .DIV_W(DW),
        .FBDSEL_TABLE(FB_T), .IDSEL_TABLE(ID_T), .ODSEL_TABLE(OD_T),
        .DEFAULT_MODE(0), .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT),
        .SETTLE_CYCLES(SC), .MAX_RETRIES(MR)
    ) dut (
        .clk(clk), .reset(reset), .mode_req(mode_req), .mode_req_valid(mode_req_valid),
        .mode_req_ready(mode_req_ready), .pll_lock(pll_lock), .fbdsel(fbdsel), .idsel(idsel),
        .odsel(odsel), .pll_reset(pll_reset), .video_rst(video_rst), .mode_active(mode_active),
        .busy(busy), .error(error), .lock_lost(lock_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [17:0] exp_sel(input int m);
        exp_sel = {6'(fb_tab[m]), 6'(id_tab[m]), 6'(od_tab[m])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts pll_reset-high cycles starting with the current sample; ends on the first low cycle.
    task automatic check_reset_pulse();
        int n;
        n = 0;
        for (int i = 0; i < RC + 8; i++) begin
            if (pll_reset) n++;
            else if (n > 0) break;
            tick();
        end
        tests_run++; if (n != RC) begin tests_failed++; $display("FAIL pll_reset_len: got %0d want %0d", n, RC); end
    endtask

    // Raises lock after d cycles, expects video_rst to fall LOCK_TO_RUN cycles later and an idle mode m.
    task automatic settle_and_check(input int m, input int d);
        int lat;
        logic early;
        lat = 0;
        early = 1'b0;
        repeat (d) begin
            tick();
            if (!video_rst || pll_reset) early = 1'b1;
        end
        pll_lock = 1'b1;
        for (int i = 0; i < LOCK_TO_RUN + 20; i++) begin
            tick();
            lat++;
            if (!video_rst) break;
            if (pll_reset) early = 1'b1;
        end
        tests_run++; if (early) begin tests_failed++; $display("FAIL settle_window: got early release/pll_reset want none"); end
        tests_run++; if (lat != LOCK_TO_RUN) begin tests_failed++; $display("FAIL settle_latency: got %0d want %0d", lat, LOCK_TO_RUN); end
        tests_run++; if (mode_active !== MW'(m)) begin tests_failed++; $display("FAIL mode_active: got %0d want %0d", mode_active, m); end
        tests_run++; if (sel !== exp_sel(m)) begin tests_failed++; $display("FAIL selects_idle: got %0h want %0h", sel, exp_sel(m)); end
        tests_run++; if (st !== 5'b01000) begin tests_failed++; $display("FAIL idle_status: got %b want 01000", st); end
        exp_active = m;
        exp_error = 0;
    endtask

    task automatic finish_retune(input int m, input int d);
        check_reset_pulse();
        settle_and_check(m, d);
    endtask

    task automatic test_reset();
        reset = 1'b1; mode_req_valid = 1'b0; mode_req = '0; pll_lock = 1'b0;
        repeat (3) tick();
        tests_run++; if ({st, pll_reset} !== 6'b101001) begin tests_failed++; $display("FAIL reset_status: got %b want 101001", {st, pll_reset}); end
        tests_run++; if (sel !== exp_sel(0)) begin tests_failed++; $display("FAIL reset_selects: got %0h want %0h", sel, exp_sel(0)); end
        tests_run++; if (mode_active !== 3'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d want 0", mode_active); end
        reset = 1'b0;
        exp_active = 0;
        finish_retune(0, 20 - RC);
    endtask

    task automatic test_mode_switch(input int m, input int d);
        tests_run++; if (mode_req_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_before_req: got %b want 1", mode_req_ready); end
        mode_req = MW'(m); mode_req_valid = 1'b1; pll_lock = 1'b0;
        tick();
        mode_req = MW'((m + 1) % NM);
        tests_run++; if (sel !== exp_sel(m)) begin tests_failed++; $display("FAIL sel_after_accept: got %0h want %0h", sel, exp_sel(m)); end
        tests_run++; if ({st, pll_reset} !== {1'b1, 1'b0, 1'b1, exp_error[0], 1'b0, 1'b0}) begin
            tests_failed++; $display("FAIL apply_status: got %b want %b", {st, pll_reset}, {1'b1, 1'b0, 1'b1, exp_error[0], 1'b0, 1'b0}); end
        tick();
        mode_req_valid = 1'b0;
        finish_retune(m, d);
    endtask

    task automatic test_bad_mode(input int m);
        mode_req = MW'(m); mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        tests_run++; if (st !== 5'b01010) begin tests_failed++; $display("FAIL bad_mode_status: got %b want 01010", st); end
        repeat (4) tick();
        tests_run++; if ({st, pll_reset} !== 6'b010100) begin tests_failed++; $display("FAIL bad_mode_hold: got %b want 010100", {st, pll_reset}); end
        tests_run++; if (sel !== exp_sel(exp_active)) begin tests_failed++; $display("FAIL bad_mode_sel: got %0h want %0h", sel, exp_sel(exp_active)); end
        tests_run++; if (mode_active !== MW'(exp_active)) begin tests_failed++; $display("FAIL bad_mode_active: got %0d want %0d", mode_active, exp_active); end
        exp_error = 1;
    endtask

    task automatic test_lock_glitch(input int m, input int g);
        logic bad;
        mode_req = MW'(m); mode_req_valid = 1'b1; pll_lock = 1'b0;
        tick();
        mode_req_valid = 1'b0;
        check_reset_pulse();
        pll_lock = 1'b1;
        bad = 1'b0;
        repeat (g) begin tick(); bad = bad | !video_rst | pll_reset; end
        pll_lock = 1'b0;
        repeat (3) begin tick(); bad = bad | !video_rst | pll_reset; end
        tests_run++; if (bad) begin tests_failed++; $display("FAIL glitch_hold: got release/pll_reset want video_rst held g=%0d", g); end
        settle_and_check(m, 0);
    endtask

    task automatic test_idle_lock_loss();
        int lost_n, lost_t;
        logic pr;
        logic [4:0] s3;
        pll_lock = 1'b0;
        lost_n = 0; lost_t = -1; pr = 1'b0; s3 = '0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (lock_lost) begin lost_n++; lost_t = i; end
            pr = pr | pll_reset;
            if (i == 3) s3 = st;
        end
        tests_run++; if (lost_n != 1 || lost_t != 3) begin tests_failed++; $display("FAIL lock_lost_pulse: got n=%0d at %0d want n=1 at 3", lost_n, lost_t); end
        tests_run++; if (s3 !== {1'b1, 1'b0, 1'b1, exp_error[0], 1'b1}) begin tests_failed++; $display("FAIL loss_status: got %b want %b", s3, {1'b1, 1'b0, 1'b1, exp_error[0], 1'b1}); end
        tests_run++; if (pr) begin tests_failed++; $display("FAIL loss_pll_reset: got 1 want 0"); end
        tests_run++; if (sel !== exp_sel(exp_active)) begin tests_failed++; $display("FAIL loss_sel: got %0h want %0h", sel, exp_sel(exp_active)); end
        settle_and_check(exp_active, $urandom_range(0, 30));
    endtask

    task automatic test_simultaneous(input int m);
        pll_lock = 1'b0;
        tick();
        tick();
        mode_req = MW'(m); mode_req_valid = 1'b1;
        tick();
        mode_req_valid = 1'b0;
        tests_run++; if (lock_lost !== 1'b1) begin tests_failed++; $display("FAIL simul_lock_lost: got %b want 1", lock_lost); end
        tests_run++; if (sel !== exp_sel(m)) begin tests_failed++; $display("FAIL simul_sel: got %0h want %0h", sel, exp_sel(m)); end
        tick();
        tests_run++; if (lock_lost !== 1'b0) begin tests_failed++; $display("FAIL simul_pulse_width: got %b want 0", lock_lost); end
        finish_retune(m, $urandom_range(0, 40));
    endtask

    task automatic test_never_lock(input int m);
        int rise[8];
        int nr, fail_t, last;
        logic prev;
        mode_req = MW'(m); mode_req_valid = 1'b1; pll_lock = 1'b0;
        tick();
        mode_req_valid = 1'b0;
        nr = 0; prev = 1'b0; fail_t = -1;
        for (int t = 1; t < (MR + 1) * (RC + LT) + 20; t++) begin
            tick();
            if (pll_reset && !prev && nr < 8) begin rise[nr] = t; nr++; end
            prev = pll_reset;
            if (mode_req_ready) begin fail_t = t; break; end
        end
        tests_run++; if (nr != MR + 1) begin tests_failed++; $display("FAIL retry_pulses: got %0d want %0d", nr, MR + 1); end
        for (int i = 1; i < nr; i++) begin
            tests_run++; if (rise[i] - rise[i-1] != RC + LT) begin tests_failed++; $display("FAIL retry_spacing: got %0d want %0d", rise[i] - rise[i-1], RC + LT); end
        end
        last = (nr > 0) ? rise[nr-1] : 0;
        tests_run++; if (fail_t - last != RC + LT) begin tests_failed++; $display("FAIL fail_entry: got %0d want %0d", fail_t - last, RC + LT); end
        tests_run++; if (st !== 5'b01110) begin tests_failed++; $display("FAIL fail_status: got %b want 01110", st); end
        tests_run++; if (sel !== exp_sel(m)) begin tests_failed++; $display("FAIL fail_sel: got %0h want %0h", sel, exp_sel(m)); end
        tests_run++; if (mode_active !== MW'(exp_active)) begin tests_failed++; $display("FAIL fail_active: got %0d want %0d", mode_active, exp_active); end
        exp_error = 1;
    endtask

    task automatic test_reset_mid();
        mode_req = 3'd2; mode_req_valid = 1'b1; pll_lock = 1'b0;
        tick();
        mode_req_valid = 1'b0;
        check_reset_pulse();
        repeat (5) tick();
        reset = 1'b1;
        tick();
        tick();
        tests_run++; if ({st, pll_reset} !== 6'b101001) begin tests_failed++; $display("FAIL mid_reset_status: got %b want 101001", {st, pll_reset}); end
        tests_run++; if (sel !== exp_sel(0)) begin tests_failed++; $display("FAIL mid_reset_sel: got %0h want %0h", sel, exp_sel(0)); end
        tests_run++; if (mode_active !== 3'd0) begin tests_failed++; $display("FAIL mid_reset_active: got %0d want 0", mode_active); end
        reset = 1'b0;
        exp_active = 0;
        exp_error = 0;
        finish_retune(0, $urandom_range(0, 40));
    endtask

    task automatic test_random();
        int m;
        for (int k = 0; k < 6; k++) begin
            m = $urandom_range(0, 7);
            if (m < NM) test_mode_switch(m, $urandom_range(0, 40));
            else test_bad_mode(m);
        end
        test_lock_glitch($urandom_range(0, NM - 1), $urandom_range(3, 8));
    endtask

    initial begin
        test_reset();
        test_mode_switch(2, 10);
        test_bad_mode(5);
        test_lock_glitch(1, 6);
        test_idle_lock_loss();
        test_simultaneous(3);
        test_never_lock(1);
        test_mode_switch(0, 25);
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
